// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {pc, instr} pairs between IF and ID.
// Latency: push visible at the head one cycle later; head entry is shown ahead with no extra read cycle.
// Backpressure: fetch_stall is raised from the registered count when full; decode holds the head with id_ready=0.
module if_id_queue #(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_valid,
    input  logic [31:0]   fetch_pc,
    input  logic [31:0]   fetch_instr,
    output logic          fetch_stall,
    input  logic          flush,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [31:0]   id_pc,
    output logic [31:0]   id_instr,
    output logic [31:0]   id_pc_plus4,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Storage is never cleared: only entries between rd and wr pointers are ever shown.
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          push;
    logic          pop;

    // Status comes only from the registered count, so id_ready never reaches fetch_stall.
    assign fetch_stall = (count_q == FULL_CNT);
    assign id_valid    = (count_q != '0);
    assign count       = count_q;

    // Flush suppresses both handshakes; full blocks push even when decode pops this cycle.
    assign push = fetch_valid && !fetch_stall && !flush;
    assign pop  = id_valid && id_ready && !flush;

    // Head entry is presented directly; an empty queue shows a NOP at PC 0.
    assign id_pc       = id_valid ? pc_mem_q[rd_ptr_q]    : 32'h0;
    assign id_instr    = id_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
    assign id_pc_plus4 = id_pc + 32'd4;

    // Next pointer/occupancy: DEPTH is a power of two so pointer wrap is natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state: reset outranks flush, which is folded into the _d values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry write at the tail on an accepted push; entries are otherwise held.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc;
            instr_mem_q[wr_ptr_q] <= fetch_instr;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: a DEPTH=2 and a DEPTH=4 instance share fetch/flush/reset stimulus.
// Expected entries live in per-instance SV queues; a negedge monitor compares outputs and pops on handshakes.
// Directed scenarios first, then randomized traffic with occasional flush and reset.
module tb_if_id_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        flush;
    logic        rdy2, rdy4;

    logic        fs2, iv2, fs4, iv4;
    logic [31:0] ipc2, iins2, ip42, ipc4, iins4, ip44;
    logic [1:0]  cnt2;
    logic [2:0]  cnt4;

    int checks   = 0;
    int failures = 0;
    bit armed    = 1'b0;

    logic [63:0] q2[$];
    logic [63:0] q4[$];

    always #5 clk = ~clk;

    if_id_queue #(.DEPTH(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .fetch_instr(fetch_instr), .fetch_stall(fs2), .flush(flush), .id_valid(iv2),
        .id_ready(rdy2), .id_pc(ipc2), .id_instr(iins2), .id_pc_plus4(ip42), .count(cnt2)
    );

    if_id_queue #(.DEPTH(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .fetch_instr(fetch_instr), .fetch_stall(fs4), .flush(flush), .id_valid(iv4),
        .id_ready(rdy4), .id_pc(ipc4), .id_instr(iins4), .id_pc_plus4(ip44), .count(cnt4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // Monitor: compare against the expected queue contents, then advance the model across the next edge.
    always @(negedge clk) begin
        logic [63:0] h2, h4;
        logic        acc2, acc4;
        if (armed) begin
            h2 = (q2.size() != 0) ? q2[0] : 64'h0;
            h4 = (q4.size() != 0) ? q4[0] : 64'h0;
            chk("d2_count", {30'b0, cnt2}, 32'(q2.size()));
            chk("d2_stall", {31'b0, fs2},  {31'b0, q2.size() == 2});
            chk("d2_valid", {31'b0, iv2},  {31'b0, q2.size() != 0});
            chk("d2_pc",    ipc2,  h2[63:32]);
            chk("d2_instr", iins2, h2[31:0]);
            chk("d2_plus4", ip42,  h2[63:32] + 32'd4);
            chk("d4_count", {29'b0, cnt4}, 32'(q4.size()));
            chk("d4_stall", {31'b0, fs4},  {31'b0, q4.size() == 4});
            chk("d4_valid", {31'b0, iv4},  {31'b0, q4.size() != 0});
            chk("d4_pc",    ipc4,  h4[63:32]);
            chk("d4_instr", iins4, h4[31:0]);
            chk("d4_plus4", ip44,  h4[63:32] + 32'd4);
        end
        if (!rst_n) begin
            q2.delete();
            q4.delete();
            armed = 1'b1;
        end else if (armed) begin
            if (flush) begin
                q2.delete();
                q4.delete();
            end else begin
                acc2 = fetch_valid && (q2.size() < 2);
                acc4 = fetch_valid && (q4.size() < 4);
                if (iv2 && rdy2 && q2.size() != 0) void'(q2.pop_front());
                if (iv4 && rdy4 && q4.size() != 0) void'(q4.pop_front());
                if (acc2) q2.push_back({fetch_pc, fetch_instr});
                if (acc4) q4.push_back({fetch_pc, fetch_instr});
            end
        end
    end

    task automatic step(input logic fv, input logic [31:0] pc, input logic fl,
                        input logic r2, input logic r4);
        fetch_valid = fv;
        fetch_pc    = pc;
        fetch_instr = pc ^ 32'hA5A5_0013;
        flush       = fl;
        rdy2        = r2;
        rdy4        = r4;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, r, r);
    endtask

    initial begin
        rst_n = 1'b0;
        fetch_valid = 1'b0; fetch_pc = '0; fetch_instr = '0;
        flush = 1'b0; rdy2 = 1'b0; rdy4 = 1'b0;
        idle(2, 1'b0);
        rst_n = 1'b1;
        idle(2, 1'b1);

        // Streaming with decode always ready.
        step(1'b1, 32'h00, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h04, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h08, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Fill with decode stalled; third push rejected by the 2-deep queue.
        step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h30, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0,  1'b0, 1'b0, 1'b0);
        idle(5, 1'b1);

        // Full with simultaneous pop.
        step(1'b1, 32'h50, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h54, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h58, 1'b0, 1'b1, 1'b1);
        idle(5, 1'b1);

        // Flush with a competing push, then a fresh push.
        step(1'b1, 32'h60, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h64, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h40, 1'b1, 1'b1, 1'b1);
        step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0,  1'b0, 1'b0, 1'b0);
        idle(3, 1'b1);

        // Wrap: nine entries through both queues, plus the PC+4 overflow case.
        for (int i = 0; i < 9; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b1, (i % 3) != 2);
        idle(6, 1'b1);
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b1);

        // Reset mid-fill with every other control active.
        step(1'b1, 32'h70, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h74, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h78, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step(1'b1, 32'h7C, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0,   1'b0, 1'b0, 1'b0);
        idle(4, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
        end
        rst_n = 1'b1;
        idle(6, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter: DEPTH, 2, number of fetch-queue entries; only 2 or 4 are legal; CW = log2(DEPTH)+1.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 fetch_valid  in  1  fetch stage presents an instruction this cycle.
REQ-005 fetch_pc  in  32  PC of the presented instruction (fetch pc_out).
REQ-006 fetch_instr  in  32  presented instruction word (fetch output_instr).
REQ-007 fetch_stall  out  1  queue cannot accept; fetch holds its PC.
REQ-008 flush  in  1  branch redirect; discard all queued and incoming instructions.
REQ-009 id_valid  out  1  head entry valid for decode.
REQ-010 id_ready  in  1  decode accepts the head entry this cycle.
REQ-011 id_pc  out  32  PC of the head entry.
REQ-012 id_instr  out  32  instruction of the head entry.
REQ-013 id_pc_plus4  out  32  id_pc + 4, modulo 2^32.
REQ-014 count  out  CW  number of occupied entries, 0..DEPTH.

Function
REQ-015 The block SHALL be a circular FIFO with registered storage, write pointer, read pointer and occupancy count.
REQ-016 Push SHALL occur on a rising edge when fetch_valid=1, fetch_stall=0 and flush=0; the {fetch_pc, fetch_instr} pair is stored at the write pointer.
REQ-017 Pop SHALL occur on a rising edge when id_valid=1, id_ready=1 and flush=0; the read pointer advances.
REQ-018 fetch_stall SHALL equal (count == DEPTH), derived from registered count only, with no combinational path from id_ready.
REQ-019 At full with id_ready=1, the pop SHALL occur and the push SHALL NOT; count becomes DEPTH-1 and fetch_stall deasserts the next cycle.
REQ-020 Simultaneous push and pop at 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-021 id_valid SHALL equal (count != 0); show-ahead: id_pc/id_instr SHALL reflect the head entry in the same cycle id_valid rises, with no extra latency. Push-to-visible latency is one cycle.
REQ-022 With count == 0, id_pc SHALL be 32'h0, id_instr SHALL be 32'h0 (NOP) and id_pc_plus4 SHALL be 32'h4.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-024 flush=1 SHALL, on that edge, set count=0 and both pointers=0, and SHALL drop any same-cycle push or pop; id_valid=0 the following cycle.
REQ-025 flush SHALL take priority over push and pop, and rst_n=0 SHALL take priority over flush.
REQ-026 id_pc_plus4 SHALL be combinational from id_pc; overflow at 32'hFFFFFFFC SHALL wrap to 32'h0.
REQ-027 Stored entries SHALL NOT change while id_ready=0; decode-side stall holds id_* stable.

Reset
REQ-028 On a rising edge with rst_n=0: count=0, pointers=0, id_valid=0, fetch_stall=0, id_pc=0, id_instr=0, id_pc_plus4=4; storage contents need not be cleared.
REQ-029 Reset asserted mid-operation SHALL discard all entries within one edge, regardless of fetch_valid, id_ready or flush.

Verification
REQ-030 Streaming: id_ready=1, push PCs 0x00,0x04,0x08 on consecutive cycles -> id_pc 0x00,0x04,0x08 one cycle later each, count stays 1, fetch_stall never set.
REQ-031 Fill: DEPTH=2, id_ready=0, push 0x10/0x20 -> count=2, fetch_stall=1; a third push of 0x30 is ignored; raise id_ready -> pops 0x10 then 0x20, and 0x30 is never output unless re-presented.
REQ-032 Full with simultaneous pop: count=2, fetch_valid=1, id_ready=1 -> count=1 after the edge, no push that cycle.
REQ-033 Flush: count=2, flush=1 with fetch_valid=1, fetch_pc=0x40 -> count=0, id_valid=0, id_instr=0; next push of PC 0x10 appears at id_pc=0x10.
REQ-034 Wrap: DEPTH=4, push/pop 9 entries PC 0x00..0x20 -> in-order output, no loss or duplication; id_pc_plus4 for PC 0xFFFFFFFC reads 0x0.
REQ-035 Reset mid-fill: count=3, rst_n=0 for one edge -> all outputs at reset values; a subsequent push of 0x100 appears correctly.
